// File: rtl/mcp9808_pkg.sv
// Shared types and widths for the MCP9808 multi-sensor poller.
package mcp9808_pkg;

    localparam int unsigned TEMP_W   = 12;
    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned COMP_W   = 3;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned MINMAX_W = SIGN_W + TEMP_W;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StStore,
        StNext
    } state_e;

    typedef struct packed {
        logic [TEMP_W-1:0] temp;
        logic              sign;
        logic [COMP_W-1:0] comp;
    } reading_t;

    // True when {sign, magnitude} value a ranks strictly below b; any negative is below any
    // non-negative, and a larger negative magnitude is lower.
    function automatic logic sm_less(input logic [MINMAX_W-1:0] a,
                                     input logic [MINMAX_W-1:0] b);
        int va;
        int vb;
        va = a[TEMP_W] ? -int'(a[TEMP_W-1:0]) : int'(a[TEMP_W-1:0]);
        vb = b[TEMP_W] ? -int'(b[TEMP_W-1:0]) : int'(b[TEMP_W-1:0]);
        return va < vb;
    endfunction

endpackage

// File: rtl/mcp9808_slot.sv
// One channel's stored reading, valid and sticky-error flags, plus optional running
// max/min (enabled by MCP9808_POLLER_MINMAX_EN).
module mcp9808_slot
    import mcp9808_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                store,
    input  logic                set_err,
    input  reading_t            rd_in,
    output reading_t            rd_out,
    output logic                valid,
    output logic                err,
    output logic                alert
`ifdef MCP9808_POLLER_MINMAX_EN
    ,
    output logic [MINMAX_W-1:0] max_out,
    output logic [MINMAX_W-1:0] min_out
`endif
);

    reading_t data_q, data_d;
    logic     valid_q, valid_d;
    logic     err_q, err_d;

    // A store always wins over a timeout; the two never coincide for one channel.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (store) begin
            data_d  = rd_in;
            valid_d = 1'b1;
            err_d   = 1'b0;
        end else if (set_err) begin
            err_d = 1'b1;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rd_out = data_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign alert  = valid_q & (|data_q.comp);

`ifdef MCP9808_POLLER_MINMAX_EN
    logic [MINMAX_W-1:0] max_q, max_d;
    logic [MINMAX_W-1:0] min_q, min_d;
    logic [MINMAX_W-1:0] new_v;

    assign new_v = {rd_in.sign, rd_in.temp};

    // The first reading seeds both extremes; later readings only widen the range.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (store) begin
            if (!valid_q) begin
                max_d = new_v;
                min_d = new_v;
            end else begin
                if (sm_less(max_q, new_v)) max_d = new_v;
                if (sm_less(new_v, min_q)) min_d = new_v;
            end
        end
    end

    // Extreme-value registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_out = max_q;
    assign min_out = min_q;
`endif

endmodule

// File: rtl/mcp9808_poller.sv
// Scans CH MCP9808 sensors through a shared read core, one transaction per channel, on
// request or periodically. Optional per-channel max/min tracking under
// MCP9808_POLLER_MINMAX_EN adds rd_max/rd_min.
module mcp9808_poller
    import mcp9808_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter logic [23:0] ADDR_LIST   = 24'o76543210,
    parameter int unsigned PERIOD_CYC  = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    localparam int unsigned CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                auto_en,
    input  logic                scan_req,
    output logic [ADDR_W-1:0]   core_addr,
    output logic                core_update,
    input  logic                core_ready,
    input  logic [TEMP_W-1:0]   core_temp,
    input  logic                core_sign,
    input  logic [COMP_W-1:0]   core_comp,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [TEMP_W-1:0]   rd_temp,
    output logic                rd_sign,
    output logic [COMP_W-1:0]   rd_comp,
    output logic                rd_valid,
`ifdef MCP9808_POLLER_MINMAX_EN
    output logic [MINMAX_W-1:0] rd_max,
    output logic [MINMAX_W-1:0] rd_min,
`endif
    output logic [CH-1:0]       alert,
    output logic [CH-1:0]       err,
    output logic                busy,
    output logic                scan_done
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [31:0]       per_cnt_q, per_cnt_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              pending_q, pending_d;
    logic              core_update_q, core_update_d;
    logic              scan_done_q, scan_done_d;
    logic              per_hit;
    logic              tmo_exp;
    logic              tmo_hit;

    reading_t          core_rd;
    reading_t          data_v [CH];
    logic [CH-1:0]     valid_v;
    logic [ADDR_W-1:0] addr_tbl [CH];

    assign core_rd.temp = core_temp;
    assign core_rd.sign = core_sign;
    assign core_rd.comp = core_comp;

    assign per_hit = auto_en && (per_cnt_q == PERIOD_CYC - 1);
    assign tmo_exp = (tmo_cnt_q >= TIMEOUT_CYC);

    // Next-state logic for the scan sequencer, period counter and pending flag.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        tmo_cnt_d     = tmo_cnt_q;
        pending_d     = pending_q;
        core_update_d = 1'b0;
        scan_done_d   = 1'b0;
        tmo_hit       = 1'b0;
        per_cnt_d     = auto_en ? (per_hit ? 32'd0 : per_cnt_q + 32'd1) : 32'd0;

        // Only one missed period is remembered, however many expire during a scan.
        if (per_hit && state_q != StIdle) pending_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (scan_req || per_hit || pending_q) begin
                    state_d   = StIssue;
                    ch_d      = '0;
                    tmo_cnt_d = '0;
                    pending_d = 1'b0;
                end
            end
            StIssue: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_exp) begin
                    tmo_hit = 1'b1;
                    state_d = StNext;
                end else if (core_ready) begin
                    core_update_d = 1'b1;
                    state_d       = StWaitBusy;
                end
            end
            StWaitBusy: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_exp) begin
                    tmo_hit = 1'b1;
                    state_d = StNext;
                end else if (!core_ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_exp) begin
                    tmo_hit = 1'b1;
                    state_d = StNext;
                end else if (core_ready) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                state_d = StNext;
            end
            StNext: begin
                if (ch_q == CH_W'(CH - 1)) begin
                    scan_done_d = 1'b1;
                    ch_d        = '0;
                    state_d     = StIdle;
                end else begin
                    ch_d      = ch_q + 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = StIssue;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ch_q          <= '0;
            per_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            pending_q     <= 1'b0;
            core_update_q <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            per_cnt_q     <= per_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            pending_q     <= pending_d;
            core_update_q <= core_update_d;
            scan_done_q   <= scan_done_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign core_update = core_update_q;
    assign scan_done   = scan_done_q;
    assign core_addr   = busy ? addr_tbl[ch_q] : addr_tbl[0];

`ifdef MCP9808_POLLER_MINMAX_EN
    logic [MINMAX_W-1:0] max_v [CH];
    logic [MINMAX_W-1:0] min_v [CH];
`endif

    for (genvar i = 0; i < CH; i++) begin : g_slot
        assign addr_tbl[i] = ADDR_LIST[ADDR_W*i +: ADDR_W];

        mcp9808_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .store   ((state_q == StStore) && (ch_q == CH_W'(i))),
            .set_err (tmo_hit && (ch_q == CH_W'(i))),
            .rd_in   (core_rd),
            .rd_out  (data_v[i]),
            .valid   (valid_v[i]),
            .err     (err[i]),
            .alert   (alert[i])
`ifdef MCP9808_POLLER_MINMAX_EN
            ,
            .max_out (max_v[i]),
            .min_out (min_v[i])
`endif
        );
    end

    // Read port: out-of-range channels read as an empty, invalid slot.
    always_comb begin
        rd_temp  = '0;
        rd_sign  = 1'b0;
        rd_comp  = '0;
        rd_valid = 1'b0;
`ifdef MCP9808_POLLER_MINMAX_EN
        rd_max   = '0;
        rd_min   = '0;
`endif
        if (32'(rd_ch) < CH) begin
            rd_temp  = data_v[rd_ch].temp;
            rd_sign  = data_v[rd_ch].sign;
            rd_comp  = data_v[rd_ch].comp;
            rd_valid = valid_v[rd_ch];
`ifdef MCP9808_POLLER_MINMAX_EN
            rd_max   = max_v[rd_ch];
            rd_min   = min_v[rd_ch];
`endif
        end
    end

endmodule

// File: tb/tb_mcp9808_poller.sv
// Bench for mcp9808_poller: randomized core model, address scoreboard and slot reference.
`timescale 1ns/1ps
module tb_mcp9808_poller;

    localparam int unsigned CH          = 4;
    localparam int unsigned PERIOD_CYC  = 200;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam logic [23:0] ADDR_LIST   = 24'o76543210;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          auto_en = 1'b0;
    logic          scan_req = 1'b0;
    logic [2:0]    core_addr;
    logic          core_update;
    logic          core_ready;
    logic [11:0]   core_temp;
    logic          core_sign;
    logic [2:0]    core_comp;
    logic [1:0]    rd_ch = 2'd0;
    logic [11:0]   rd_temp;
    logic          rd_sign;
    logic [2:0]    rd_comp;
    logic          rd_valid;
    logic [CH-1:0] alert;
    logic [CH-1:0] err;
    logic          busy;
    logic          scan_done;
`ifdef MCP9808_POLLER_MINMAX_EN
    logic [12:0]   rd_max;
    logic [12:0]   rd_min;
`endif

    always #5 clk = ~clk;

    mcp9808_poller #(
        .CH          (CH),
        .ADDR_LIST   (ADDR_LIST),
        .PERIOD_CYC  (PERIOD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .auto_en     (auto_en),
        .scan_req    (scan_req),
        .core_addr   (core_addr),
        .core_update (core_update),
        .core_ready  (core_ready),
        .core_temp   (core_temp),
        .core_sign   (core_sign),
        .core_comp   (core_comp),
        .rd_ch       (rd_ch),
        .rd_temp     (rd_temp),
        .rd_sign     (rd_sign),
        .rd_comp     (rd_comp),
        .rd_valid    (rd_valid),
`ifdef MCP9808_POLLER_MINMAX_EN
        .rd_max      (rd_max),
        .rd_min      (rd_min),
`endif
        .alert       (alert),
        .err         (err),
        .busy        (busy),
        .scan_done   (scan_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference slots, next readings the core will return, and core behaviour knobs.
    logic [11:0] ref_temp [CH];
    logic        ref_sign [CH];
    logic [2:0]  ref_comp [CH];
    logic        ref_valid [CH];
    logic        ref_err [CH];
    logic [11:0] nxt_temp [CH];
    logic        nxt_sign [CH];
    logic [2:0]  nxt_comp [CH];
    int          dead_ch = -1;
    int          busy_min = 3;
    int          busy_max = 20;
    int          rst_gen = 0;

    // Scoreboard and monitor bookkeeping.
    logic [2:0]    exp_addr [$];
    int            cyc = 0;
    int            upd_cnt = 0;
    int            done_cnt = 0;
    int            last_upd_cyc = 0;
    int            last_done_cyc = 0;
    int            upd_cyc [CH];
    int            err_rise_cyc [CH];
    logic          prev_upd = 1'b0;
    logic [CH-1:0] prev_err = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] addr_field(input int i);
        logic [23:0] list;
        list = ADDR_LIST;
        return list[3*i +: 3];
    endfunction

    function automatic int ch_of_addr(input logic [2:0] a);
        for (int i = 0; i < CH; i++) if (addr_field(i) == a) return i;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ref_clear();
        for (int i = 0; i < CH; i++) begin
            ref_temp[i]  = '0;
            ref_sign[i]  = 1'b0;
            ref_comp[i]  = '0;
            ref_valid[i] = 1'b0;
            ref_err[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        scan_req = 1'b0;
        auto_en  = 1'b0;
        tick(3);
        rst_gen++;
        exp_addr.delete();
        ref_clear();
        rst = 1'b0;
        tick(1);
    endtask

    task automatic set_random_data();
        for (int i = 0; i < CH; i++) begin
            nxt_temp[i] = 12'($urandom);
            nxt_sign[i] = 1'($urandom);
            nxt_comp[i] = 3'($urandom);
        end
    endtask

    task automatic set_all_data(input logic [11:0] t, input logic s, input logic [2:0] c);
        for (int i = 0; i < CH; i++) begin
            nxt_temp[i] = t;
            nxt_sign[i] = s;
            nxt_comp[i] = c;
        end
    endtask

    task automatic pulse_scan_req();
        scan_req = 1'b1;
        tick(1);
        scan_req = 1'b0;
    endtask

    // One requested scan: expect every channel address once, then one scan_done.
    task automatic run_scan(input string tag, input bit mid_req);
        int d0;
        int n;
        d0 = done_cnt;
        for (int i = 0; i < CH; i++) exp_addr.push_back(addr_field(i));
        pulse_scan_req();
        if (mid_req) begin
            tick(15);
            pulse_scan_req();
        end
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            tick(1);
            n++;
        end
        check({tag, "_scan_done_count"}, done_cnt - d0, 1);
        tick(2);
        check({tag, "_addr_queue_empty"}, exp_addr.size(), 0);
    endtask

    task automatic check_slots(input string tag);
        logic [CH-1:0] ea;
        logic [CH-1:0] ee;
        for (int i = 0; i < CH; i++) begin
            rd_ch = 2'(i);
            #1;
            check($sformatf("%s_temp_ch%0d", tag, i), rd_temp, ref_temp[i]);
            check($sformatf("%s_sign_ch%0d", tag, i), rd_sign, ref_sign[i]);
            check($sformatf("%s_comp_ch%0d", tag, i), rd_comp, ref_comp[i]);
            check($sformatf("%s_valid_ch%0d", tag, i), rd_valid, ref_valid[i]);
            ea[i] = ref_valid[i] && (ref_comp[i] != 3'd0);
            ee[i] = ref_err[i];
        end
        check({tag, "_alert"}, alert, ea);
        check({tag, "_err"}, err, ee);
        tick(1);
    endtask

    // Core model: drops ready shortly after each update, returns the channel's next reading.
    initial begin : core_model
        int a;
        int g;
        core_ready = 1'b1;
        core_temp  = '0;
        core_sign  = 1'b0;
        core_comp  = '0;
        forever begin
            @(negedge clk);
            if (core_update) begin
                a = ch_of_addr(core_addr);
                if (a < 0) a = 0;
                g = rst_gen;
                repeat ($urandom_range(2, 1)) @(negedge clk);
                core_ready = 1'b0;
                if (a == dead_ch) begin
                    if (g == rst_gen) ref_err[a] = 1'b1;
                    repeat (TIMEOUT_CYC + 20) @(negedge clk);
                    core_ready = 1'b1;
                end else begin
                    repeat ($urandom_range(busy_max, busy_min)) @(negedge clk);
                    core_temp  = nxt_temp[a];
                    core_sign  = nxt_sign[a];
                    core_comp  = nxt_comp[a];
                    core_ready = 1'b1;
                    if (g == rst_gen) begin
                        ref_temp[a]  = nxt_temp[a];
                        ref_sign[a]  = nxt_sign[a];
                        ref_comp[a]  = nxt_comp[a];
                        ref_valid[a] = 1'b1;
                        ref_err[a]   = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the expected address for every core_update pulse.
    initial begin : monitor
        int c;
        forever begin
            @(negedge clk);
            cyc++;
            if (core_update) begin
                upd_cnt++;
                last_upd_cyc = cyc;
                check("core_update_one_cycle", prev_upd, 0);
                if (exp_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_core_update: addr %0d, none expected", core_addr);
                end else begin
                    check("core_addr", core_addr, exp_addr.pop_front());
                end
                c = ch_of_addr(core_addr);
                if (c >= 0) upd_cyc[c] = cyc;
            end
            prev_upd = core_update;
            for (int i = 0; i < CH; i++) if (err[i] && !prev_err[i]) err_rise_cyc[i] = cyc;
            prev_err = err;
            if (scan_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int u0;
        int d0;
        int n;
        int delta;
        set_all_data(12'h000, 1'b0, 3'd0);
        ref_clear();
        do_reset();

        // Reset state.
        check("reset_busy", busy, 0);
        check("reset_core_update", core_update, 0);
        check("reset_scan_done", scan_done, 0);
        check("reset_core_addr", core_addr, addr_field(0));
        check_slots("reset");

        // Fixed 0x1A3 on every channel.
        set_all_data(12'h1A3, 1'b0, 3'd0);
        u0 = upd_cnt;
        run_scan("fixed", 1'b0);
        check("fixed_update_count", upd_cnt - u0, CH);
        for (int i = 0; i < CH; i++) begin
            rd_ch = 2'(i);
            #1;
            check($sformatf("fixed_temp_1a3_ch%0d", i), rd_temp, 12'h1A3);
            check($sformatf("fixed_valid_ch%0d", i), rd_valid, 1);
            tick(1);
        end
        check("idle_core_addr", core_addr, addr_field(0));

        // Channel 2 never completes: timeout sets err[2], scan still reaches channel 3.
        do_reset();
        set_random_data();
        dead_ch = 2;
        run_scan("timeout", 1'b0);
        check("timeout_err_vector", err, 4'b0100);
        delta = err_rise_cyc[2] - upd_cyc[2];
        check("timeout_latency_in_window",
              (delta >= int'(TIMEOUT_CYC) - 1) && (delta <= int'(TIMEOUT_CYC) + 1), 1);
        rd_ch = 2'd2;
        #1;
        check("timeout_ch2_valid", rd_valid, 0);
        rd_ch = 2'd3;
        #1;
        check("timeout_ch3_valid", rd_valid, 1);
        tick(1);
        check_slots("timeout");
        dead_ch = -1;
        tick(TIMEOUT_CYC + 40);

        // A later good reading clears the sticky error.
        set_random_data();
        run_scan("recover", 1'b0);
        check("recover_err_vector", err, 4'b0000);
        check_slots("recover");

        // Random readings, with scan_req pulses during a scan that must be ignored.
        for (int k = 0; k < 4; k++) begin
            set_random_data();
            run_scan($sformatf("rand%0d", k), 1'($urandom));
            check_slots($sformatf("rand%0d", k));
        end

        // Alert follows the stored comparator bits.
        set_all_data(12'h0C8, 1'b0, 3'd0);
        nxt_comp[1] = 3'b010;
        run_scan("alert_set", 1'b0);
        check("alert_ch1_only", alert, 4'b0010);
        set_all_data(12'h0C9, 1'b0, 3'd0);
        run_scan("alert_clr", 1'b0);
        check("alert_cleared", alert, 4'b0000);

`ifdef MCP9808_POLLER_MINMAX_EN
        // Running extremes with sign-magnitude ordering.
        do_reset();
        set_all_data(12'h050, 1'b0, 3'd0);
        run_scan("mm0", 1'b0);
        set_all_data(12'h010, 1'b1, 3'd0);
        run_scan("mm1", 1'b0);
        set_all_data(12'h100, 1'b0, 3'd0);
        run_scan("mm2", 1'b0);
        rd_ch = 2'd0;
        #1;
        check("minmax_max", rd_max, {1'b0, 12'h100});
        check("minmax_min", rd_min, {1'b1, 12'h010});
        tick(1);
`endif

        // Auto mode: two expiries during one ~300-cycle scan queue exactly one more scan.
        do_reset();
        busy_min = 70;
        busy_max = 70;
        set_random_data();
        auto_en = 1'b1;
        tick(150);
        for (int s = 0; s < 2; s++) for (int i = 0; i < CH; i++) exp_addr.push_back(addr_field(i));
        u0 = upd_cnt;
        d0 = done_cnt;
        pulse_scan_req();
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            tick(1);
            n++;
        end
        check("auto_first_scan_done", done_cnt - d0, 1);
        n = 0;
        while (upd_cnt < u0 + CH + 1 && n < 20) begin
            tick(1);
            n++;
        end
        check("auto_pending_started", upd_cnt - u0, CH + 1);
        delta = last_upd_cyc - last_done_cyc;
        check("auto_pending_gap", (delta >= 1) && (delta <= 3), 1);
        tick(3);
        auto_en = 1'b0;
        n = 0;
        while (done_cnt < d0 + 2 && n < 3000) begin
            tick(1);
            n++;
        end
        tick(600);
        check("auto_total_updates", upd_cnt - u0, 2 * CH);
        check("auto_total_scans", done_cnt - d0, 2);
        check("auto_addr_queue_empty", exp_addr.size(), 0);
        check_slots("auto");

        // Reset while the core is busy (sequencer waiting for completion).
        do_reset();
        busy_min = 30;
        busy_max = 30;
        set_random_data();
        for (int i = 0; i < CH; i++) exp_addr.push_back(addr_field(i));
        u0 = upd_cnt;
        pulse_scan_req();
        n = 0;
        while (upd_cnt == u0 && n < 50) begin
            tick(1);
            n++;
        end
        n = 0;
        while (core_ready && n < 10) begin
            tick(1);
            n++;
        end
        tick(3);
        check("midrst_core_busy", core_ready, 0);
        rst = 1'b1;
        tick(1);
        check("midrst_busy", busy, 0);
        check("midrst_core_update", core_update, 0);
        check("midrst_scan_done", scan_done, 0);
        check("midrst_alert", alert, 0);
        check("midrst_err", err, 0);
        check("midrst_core_addr", core_addr, addr_field(0));
        rst_gen++;
        exp_addr.delete();
        ref_clear();
        rst = 1'b0;
        tick(200);
        check("midrst_no_further_update", upd_cnt - u0, 1);
        check("midrst_still_idle", busy, 0);
        check_slots("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcp9808_poller.md
MCP9808_POLLER -- requirements
Module: mcp9808_poller

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of sensors polled (1..8).
REQ-002 SHALL have parameter ADDR_LIST, default 24'o76543210, meaning 3-bit address pins per channel; channel i uses bits [3i+2:3i].
REQ-003 SHALL have parameter PERIOD_CYC, default 100_000_000, meaning clk cycles from one scan start to the next in auto mode.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning maximum clk cycles allowed per transaction.
REQ-005 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-006 SHALL have ports: auto_en in 1, periodic scanning; scan_req in 1, one-cycle request for a single scan.
REQ-007 SHALL have ports: core_addr out 3, address pins to sensor core; core_update out 1, one-cycle read request; core_ready in 1, core idle/done.
REQ-008 SHALL have ports: core_temp in 12, core_sign in 1, core_comp in 3, all sampled on transaction completion.
REQ-009 SHALL have ports: rd_ch in clog2(CH) (min 1), channel select; rd_temp out 12; rd_sign out 1; rd_comp out 3; rd_valid out 1.
REQ-010 SHALL have ports: alert out CH, per-channel OR of stored comp bits; err out CH, per-channel sticky timeout flag; busy out 1, scan in progress; scan_done out 1, one-cycle pulse at scan end.
REQ-011 Reset rst SHALL be synchronous, active-high; clock clk.

Function
REQ-012 SHALL use states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, NEXT.
REQ-013 IDLE SHALL start a scan at channel 0 when scan_req=1, or when auto_en=1 and the period counter reaches PERIOD_CYC-1.
REQ-014 ISSUE SHALL wait for core_ready=1, then drive core_update=1 for exactly one cycle and go to WAIT_BUSY.
REQ-015 WAIT_BUSY SHALL go to WAIT_DONE on core_ready=0.
REQ-016 WAIT_DONE SHALL go to STORE on core_ready=1.
REQ-017 STORE SHALL latch core_temp/sign/comp into the current channel's slot, set its valid bit and clear its err bit in one cycle.
REQ-018 If the per-transaction counter reaches TIMEOUT_CYC in ISSUE, WAIT_BUSY or WAIT_DONE, the block SHALL set err[ch], keep the old slot data and go to NEXT.
REQ-019 The timeout counter SHALL clear on entry to ISSUE.
REQ-020 NEXT SHALL advance the channel, or at channel CH-1 pulse scan_done and return to IDLE.
REQ-021 core_addr SHALL equal the current channel's ADDR_LIST field whenever busy=1, and channel 0's field otherwise.
REQ-022 The period counter SHALL run free while auto_en=1 and clear while auto_en=0.
REQ-023 An auto period expiring while busy SHALL be held pending and start one scan on return to IDLE; further expiries SHALL NOT queue.
REQ-024 scan_req while busy SHALL be ignored.
REQ-025 scan_req and a period expiry arriving together SHALL start one scan.
REQ-026 rd_* outputs SHALL be combinational reads of slot rd_ch.
REQ-027 rd_ch >= CH SHALL return zeros with rd_valid=0.
REQ-028 A STORE to the slot selected by rd_ch SHALL be visible on rd_* in the next cycle.
REQ-029 alert[i] SHALL equal the OR of slot i's comp bits while valid[i]=1, else 0.

Reset
REQ-030 On reset, state SHALL be IDLE, channel 0, all counters 0, all slots and valid, err and pending bits 0.
REQ-031 On reset, core_update, busy, scan_done, alert and err SHALL be 0, and core_addr SHALL be channel 0's field.
REQ-032 Reset mid-transaction SHALL abandon the transaction without issuing a further core_update.

Configuration
REQ-033 With MCP9808_POLLER_MINMAX_EN defined, the block SHALL keep per-channel max and min registers, updated in STORE using sign-magnitude compare; a negative value SHALL rank below any positive value.
REQ-034 With MCP9808_POLLER_MINMAX_EN defined, the first valid reading SHALL load both max and min.
REQ-035 With MCP9808_POLLER_MINMAX_EN defined, there SHALL be outputs rd_max out 13 and rd_min out 13, formatted {sign, temp} for rd_ch.
REQ-036 Without MCP9808_POLLER_MINMAX_EN, those registers and ports SHALL be absent.

Structure
REQ-037 The state encoding, reading field widths (12 temp, 1 sign, 3 comp) and the per-address field width SHALL be placed in shared package mcp9808_pkg.
REQ-038 There SHALL be one sub-module, mcp9808_slot, holding one channel's reading, valid, err and optional min/max; it SHALL be instantiated CH times.

Verification
REQ-039 Bench SHALL cover: CH=4, scan_req with a core model returning 0x1A3 per channel -> 4 core_update pulses with addresses 0,1,2,3, then scan_done, then rd_temp=0x1A3 and rd_valid=1 on all channels.
REQ-040 Bench SHALL cover: core model never raising ready on channel 2 -> err=4'b0100 after TIMEOUT_CYC, scan continues to channel 3, slot 2 valid stays 0.
REQ-041 Bench SHALL cover: auto_en=1, PERIOD_CYC=200, scan taking 300 cycles -> exactly one pending scan starts immediately after scan_done, no double queuing.
REQ-042 Bench SHALL cover: core_comp=3'b010 on channel 1 -> alert=4'b0010; a later reading with comp=0 -> alert=0.
REQ-043 Bench SHALL cover: with MCP9808_POLLER_MINMAX_EN, readings +0x050, sign=1 0x010, +0x100 -> rd_max={0,0x100} and rd_min={1,0x010}.
REQ-044 Bench SHALL cover: rst asserted in WAIT_DONE -> next cycle IDLE with all outputs at reset values and no core_update pulse.
